// File: rtl/rf_ctrl_pkg.sv
// rtl/rf_ctrl_pkg.sv - shared constants and grant encoding for the register-file write arbiter
//
// Purpose: register-file geometry (XLEN, NREG, REG_AW), the x0 address constant and
//          the write-port grant enum used by rf_write_arbiter and rf_scoreboard.
package rf_ctrl_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = $clog2(NREG);

  localparam logic [REG_AW-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_P    = 2'd1,
    GNT_L    = 2'd2
  } grant_e;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - pending-writeback scoreboard for long-latency destinations
//
// Purpose: tracks which registers await an L writeback, answers decode hazard queries
//          and flags protocol violations (sticky error).
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   set_valid, set_rd    reservation from decode
//   clr_valid, clr_rd    L write accepted (clears pending bit)
//   chk_valid, chk_rd    P write accepted (must not target a pending register)
//   q_rs1, q_rs2         decode source queries
//   q_hazard             either query hits a pending register (combinational)
//   busy                 pending vector, bit 0 always 0
//   err                  sticky protocol error
module rf_scoreboard
  import rf_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              set_valid,
  input  logic [REG_AW-1:0] set_rd,
  input  logic              clr_valid,
  input  logic [REG_AW-1:0] clr_rd,
  input  logic              chk_valid,
  input  logic [REG_AW-1:0] chk_rd,
  input  logic [REG_AW-1:0] q_rs1,
  input  logic [REG_AW-1:0] q_rs2,
  output logic              q_hazard,
  output logic [NREG-1:0]   busy,
  output logic              err
);

  logic [NREG-1:0] busy_q, busy_d;
  logic            err_q, err_d;
  logic            set_err, clr_err, chk_err;

  always_comb begin
    busy_d = busy_q;
    // Clear first so a same-cycle reservation of the same register wins.
    if (clr_valid) begin
      busy_d[clr_rd] = 1'b0;
    end
    if (set_valid && (set_rd != REG_X0)) begin
      busy_d[set_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    set_err = set_valid && (set_rd != REG_X0) && busy_q[set_rd] &&
              !(clr_valid && (clr_rd == set_rd));
    clr_err = clr_valid && (clr_rd != REG_X0) && !busy_q[clr_rd];
    chk_err = chk_valid && (chk_rd != REG_X0) && busy_q[chk_rd];
    err_d   = err_q | set_err | clr_err | chk_err;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  // Reads registered state only: a clear landing this cycle is not bypassed.
  assign q_hazard = ((q_rs1 != REG_X0) && busy_q[q_rs1]) ||
                    ((q_rs2 != REG_X0) && busy_q[q_rs2]);
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - shares the register-file write port between pipeline and long-latency unit
//
// Purpose: fixed priority to the pipeline writeback (P) with a starvation guard that
//          forces the long-latency unit (L) through after MAX_WAIT stalled cycles.
//          Write port outputs are combinational from the winning request.
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   p_valid/p_rd/p_data/p_ready      pipeline writeback request
//   l_valid/l_rd/l_data/l_ready      long-latency unit request
//   rsv_valid/rsv_rd                 decode reservation of an L destination
//   q_rs1/q_rs2/q_hazard             decode hazard query
//   busy                             pending scoreboard
//   rf_rd/rf_din/rf_we               register file write port
//   err                              sticky protocol error
module rf_write_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_valid,
  input  logic [REG_AW-1:0] p_rd,
  input  logic [XLEN-1:0]   p_data,
  output logic              p_ready,
  input  logic              l_valid,
  input  logic [REG_AW-1:0] l_rd,
  input  logic [XLEN-1:0]   l_data,
  output logic              l_ready,
  input  logic              rsv_valid,
  input  logic [REG_AW-1:0] rsv_rd,
  input  logic [REG_AW-1:0] q_rs1,
  input  logic [REG_AW-1:0] q_rs2,
  output logic              q_hazard,
  output logic [NREG-1:0]   busy,
  output logic [REG_AW-1:0] rf_rd,
  output logic [XLEN-1:0]   rf_din,
  output logic              rf_we,
  output logic              err
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           force_l;
  grant_e         gnt;

  assign force_l = (wait_cnt_q == WAIT_MAX);

  // Grant is gated by reset so nothing is accepted while reset is held.
  always_comb begin
    gnt = GNT_NONE;
    if (!reset) begin
      if (l_valid && force_l) begin
        gnt = GNT_L;
      end else if (p_valid) begin
        gnt = GNT_P;
      end else if (l_valid) begin
        gnt = GNT_L;
      end
    end
  end

  assign p_ready = (gnt == GNT_P);
  assign l_ready = (gnt == GNT_L);

  always_comb begin
    rf_rd  = REG_X0;
    rf_din = '0;
    unique case (gnt)
      GNT_P: begin
        rf_rd  = p_rd;
        rf_din = p_data;
      end
      GNT_L: begin
        rf_rd  = l_rd;
        rf_din = l_data;
      end
      default: ;
    endcase
  end

  // x0 writes are still accepted, they just never reach the register file.
  assign rf_we = (gnt != GNT_NONE) && (rf_rd != REG_X0);

  always_comb begin
    wait_cnt_d = '0;
    if (l_valid && !l_ready) begin
      wait_cnt_d = force_l ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  rf_scoreboard u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .set_valid (rsv_valid),
    .set_rd    (rsv_rd),
    .clr_valid (l_ready),
    .clr_rd    (l_rd),
    .chk_valid (p_ready),
    .chk_rd    (p_rd),
    .q_rs1     (q_rs1),
    .q_rs2     (q_rs2),
    .q_hazard  (q_hazard),
    .busy      (busy),
    .err       (err)
  );

endmodule
